// File: rtl/mem_arb_pkg.sv
// Shared types for the cpu/dma data-memory arbiter: FSM states, requester ids and the memory command record.
package mem_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

   localparam int ACC_MODE_W = 3;

   // Command fields are carried at a fixed ceiling width and sized to the port width at the memory interface.
   localparam int MAX_ADDR_W = 64;
   localparam int MAX_DATA_W = 64;

   typedef struct packed {
      logic                  we;
      logic [MAX_ADDR_W-1:0] addr;
      logic [ACC_MODE_W-1:0] acc_mode;
      logic [MAX_DATA_W-1:0] wdata;
   } mem_req_t;

   function automatic req_id_e gnt_to_id(input logic [1:0] gnt);
      return gnt[1] ? REQ_DMA : REQ_CPU;
   endfunction

endpackage

// File: rtl/arb2_pick.sv
// Two-way combinational picker: one-hot grant from a request pair (bit0 cpu, bit1 dma).
// MEM_ARB_RR_EN selects round-robin on contention; otherwise cpu has fixed priority.
module arb2_pick (
   input  logic [1:0] req_i,
   input  logic       last_winner_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
`ifdef MEM_ARB_RR_EN
         gnt_o = last_winner_i ? 2'b01 : 2'b10;
`else
         gnt_o = 2'b01;
`endif
      end else begin
         gnt_o = req_i;
      end
   end

`ifndef MEM_ARB_RR_EN
   logic unused_last_winner;
   assign unused_last_winner = last_winner_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between cpu and dma; grant is combinational, load data returns 1 cycle after grant.
// Losers and requests arriving during a load wait (no gnt); contention policy set by MEM_ARB_RR_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [ACC_MODE_W-1:0] cpu_acc_mode,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_W-1:0]     cpu_rdata,

   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_W-1:0]     dma_addr,
   input  logic [ACC_MODE_W-1:0] dma_acc_mode,
   input  logic [DATA_W-1:0]     dma_wdata,
   output logic                  dma_gnt,
   output logic                  dma_rvalid,
   output logic [DATA_W-1:0]     dma_rdata,

   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [ACC_MODE_W-1:0] mem_acc_mode,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   arb_state_e        state_q, state_d;
   req_id_e           owner_q, owner_d;
   req_id_e           last_winner_q, last_winner_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   logic [1:0] pick_gnt;
   logic       grant_ok;
   logic       any_gnt;
   mem_req_t   cpu_cmd, dma_cmd, sel_cmd;

   arb2_pick u_pick (
      .req_i         ({dma_req, cpu_req}),
      .last_winner_i (last_winner_q),
      .gnt_o         (pick_gnt)
   );

   // Grants only from IDLE; rst masks them directly since requests may be held through reset.
   assign grant_ok = (state_q == IDLE) && !rst;
   assign cpu_gnt  = grant_ok && pick_gnt[0];
   assign dma_gnt  = grant_ok && pick_gnt[1];
   assign any_gnt  = cpu_gnt || dma_gnt;

   always_comb begin
      cpu_cmd = '{we:       cpu_we,
                  addr:     MAX_ADDR_W'(cpu_addr),
                  acc_mode: cpu_acc_mode,
                  wdata:    MAX_DATA_W'(cpu_wdata)};
      dma_cmd = '{we:       dma_we,
                  addr:     MAX_ADDR_W'(dma_addr),
                  acc_mode: dma_acc_mode,
                  wdata:    MAX_DATA_W'(dma_wdata)};
      sel_cmd = pick_gnt[1] ? dma_cmd : cpu_cmd;
   end

   assign mem_wr_en    = any_gnt && sel_cmd.we;
   assign mem_rd_en    = any_gnt && !sel_cmd.we;
   assign mem_addr     = ADDR_W'(sel_cmd.addr);
   assign mem_acc_mode = sel_cmd.acc_mode;
   assign mem_wdata    = DATA_W'(sel_cmd.wdata);

   assign cpu_rvalid = (state_q == RD_WAIT) && (owner_q == REQ_CPU);
   assign dma_rvalid = (state_q == RD_WAIT) && (owner_q == REQ_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_winner_d = last_winner_q;
      cpu_rdata_d   = cpu_rdata_q;
      dma_rdata_d   = dma_rdata_q;
      case (state_q)
         IDLE: begin
            if (any_gnt) begin
               last_winner_d = gnt_to_id({dma_gnt, cpu_gnt});
               if (!sel_cmd.we) begin
                  state_d = RD_WAIT;
                  owner_d = gnt_to_id({dma_gnt, cpu_gnt});
               end
            end
         end
         RD_WAIT: begin
            state_d = IDLE;
            if (owner_q == REQ_CPU) begin
               cpu_rdata_d = mem_rdata;
            end else begin
               dma_rdata_d = mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= REQ_CPU;
         last_winner_q <= REQ_DMA;
         cpu_rdata_q   <= '0;
         dma_rdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_winner_q <= last_winner_d;
         cpu_rdata_q   <= cpu_rdata_d;
         dma_rdata_q   <= dma_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for single-cycle arbitration plus hand sequences for multi-cycle cases.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [2:0]  cpu_acc_mode, dma_acc_mode;
   logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_acc_mode;
   logic [31:0] mem_rdata = '0;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_acc_mode(cpu_acc_mode),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_acc_mode(dma_acc_mode),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_acc_mode(mem_acc_mode), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Memory model: one-cycle read latency, unwritten words return an address-derived pattern.
   logic [31:0]  mem [256];
   logic [255:0] wr_mask = '0;

   function automatic logic [31:0] init_val(input logic [7:0] idx);
      return (idx == 8'd8) ? 32'h1234_5678 : {8'hA5, 16'h0000, idx};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [7:0] idx);
      return wr_mask[idx] ? mem[idx] : init_val(idx);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_wr_en) begin
         mem[mem_addr[9:2]]     <= mem_wdata;
         wr_mask[mem_addr[9:2]] <= 1'b1;
      end
      if (mem_rd_en) mem_rdata <= mem_rd(mem_addr[9:2]);
   end

   // Scoreboard: a granted load pushes its expected data and return cycle; rvalid pops and compares.
   typedef struct {
      logic        id;
      logic [31:0] data;
      int          cyc;
   } sb_t;
   sb_t sb_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_gnt && !cpu_we) sb_q.push_back('{id: 1'b0, data: mem_rd(cpu_addr[9:2]), cyc: cyc + 1});
         if (dma_gnt && !dma_we) sb_q.push_back('{id: 1'b1, data: mem_rd(dma_addr[9:2]), cyc: cyc + 1});
         if (cpu_rvalid || dma_rvalid) begin
            if (sb_q.size() == 0) begin
               chk("rvalid_unexpected", {dma_rvalid, cpu_rvalid}, 2'b00);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               chk("rvalid_owner", {dma_rvalid, cpu_rvalid}, e.id ? 2'b10 : 2'b01);
               chk("rdata", e.id ? dma_rdata : cpu_rdata, e.data);
               chk("rvalid_latency", cyc, e.cyc);
            end
         end
      end
   end

   typedef struct {
      string       name;
      logic        c_req, c_we;
      logic [31:0] c_addr, c_wdata;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        e_cgnt, e_dgnt;
   } vec_t;
   vec_t vecs[9];

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb_q.delete();
      idle_inputs();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      cpu_acc_mode = 3'b010;
      dma_acc_mode = 3'b100;
      rst = 1'b1;
      idle_inputs();
      cpu_req = 1; dma_req = 1;

      // Reset state with both requests raised
      @(negedge clk);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_enables", {mem_rd_en, mem_wr_en}, 2'b00);
      chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
      chk("rst_rdata", {cpu_rdata, dma_rdata}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();

      vecs[0] = '{"cpu_st",     1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h00, 32'h0,         1, 0};
      vecs[1] = '{"dma_ld",     0, 0, 32'h00, 32'h0,         1, 0, 32'h20, 32'h0,         0, 1};
      vecs[2] = '{"both_ld",    1, 0, 32'h30, 32'h0,         1, 0, 32'h40, 32'h0,         1, 0};
      vecs[3] = '{"both_st",    1, 1, 32'h50, 32'h1111_1111, 1, 1, 32'h54, 32'h2222_2222, !RR, RR};
      vecs[4] = '{"cld_dst",    1, 0, 32'h10, 32'h0,         1, 1, 32'h58, 32'h3333_3333, 1, 0};
      vecs[5] = '{"none",       0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,         0, 0};
      vecs[6] = '{"dma_st",     0, 0, 32'h00, 32'h0,         1, 1, 32'h44, 32'h4444_4444, 0, 1};
      vecs[7] = '{"cst_dld",    1, 1, 32'h60, 32'h5555_5555, 1, 0, 32'h44, 32'h0,         1, 0};
      vecs[8] = '{"both_ld2",   1, 0, 32'h54, 32'h0,         1, 0, 32'h50, 32'h0,         !RR, RR};

      for (int i = 0; i < 9; i++) begin
         logic        e_we;
         logic [31:0] e_addr, e_wdata;
         logic [2:0]  e_mode;
         cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
         cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
         dma_req = vecs[i].d_req; dma_we = vecs[i].d_we;
         dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wdata;
         e_we    = vecs[i].e_dgnt ? vecs[i].d_we    : vecs[i].c_we;
         e_addr  = vecs[i].e_dgnt ? vecs[i].d_addr  : vecs[i].c_addr;
         e_wdata = vecs[i].e_dgnt ? vecs[i].d_wdata : vecs[i].c_wdata;
         e_mode  = vecs[i].e_dgnt ? 3'b100 : 3'b010;
         @(negedge clk);
         chk({vecs[i].name, "_cpu_gnt"}, cpu_gnt, vecs[i].e_cgnt);
         chk({vecs[i].name, "_dma_gnt"}, dma_gnt, vecs[i].e_dgnt);
         if (vecs[i].e_cgnt || vecs[i].e_dgnt) begin
            chk({vecs[i].name, "_enables"}, {mem_wr_en, mem_rd_en}, {e_we, !e_we});
            chk({vecs[i].name, "_addr"}, mem_addr, e_addr);
            chk({vecs[i].name, "_mode"}, mem_acc_mode, e_mode);
            if (e_we) chk({vecs[i].name, "_wdata"}, mem_wdata, e_wdata);
         end else begin
            chk({vecs[i].name, "_enables"}, {mem_wr_en, mem_rd_en}, 2'b00);
         end
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         chk({vecs[i].name, "_after_gnt"}, {cpu_gnt, dma_gnt}, 2'b00);
         chk({vecs[i].name, "_after_en"}, {mem_wr_en, mem_rd_en}, 2'b00);
         @(posedge clk); #1;
      end

      // Continuous contention on loads: alternation under round-robin, cpu only under fixed priority
      do_reset();
      cpu_req = 1; cpu_addr = 32'h30; dma_req = 1; dma_addr = 32'h40;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("contend_c%0d_cpu_gnt", k), cpu_gnt, (k % 2 == 0) && (!RR || (k % 4 == 0)));
         chk($sformatf("contend_c%0d_dma_gnt", k), dma_gnt, (k % 2 == 0) && RR && (k % 4 == 2));
         @(posedge clk); #1;
      end
      idle_inputs();

      // Request raised while a load is outstanding waits for IDLE
      do_reset();
      cpu_req = 1; cpu_addr = 32'h30;
      @(negedge clk);
      chk("rdwait_cpu_gnt", cpu_gnt, 1);
      @(posedge clk); #1;
      cpu_req = 0; dma_req = 1; dma_addr = 32'h20;
      @(negedge clk);
      chk("rdwait_dma_gnt_blocked", dma_gnt, 0);
      chk("rdwait_no_enables", {mem_wr_en, mem_rd_en}, 2'b00);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rdwait_dma_gnt_next_idle", dma_gnt, 1);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;

      // Back-to-back cpu stores, one per cycle
      for (int k = 0; k < 3; k++) begin
         cpu_req = 1; cpu_we = 1; cpu_addr = 32'(4 * k); cpu_wdata = 32'hC0DE_0000 + 32'(k);
         @(negedge clk);
         chk($sformatf("b2b_st%0d_gnt", k), {cpu_gnt, mem_wr_en}, 2'b11);
         chk($sformatf("b2b_st%0d_addr", k), mem_addr, 32'(4 * k));
         chk($sformatf("b2b_st%0d_dma_rdata_hold", k), dma_rdata, 32'h1234_5678);
         @(posedge clk); #1;
      end
      idle_inputs();

      // Reset during RD_WAIT aborts the load
      cpu_req = 1; cpu_addr = 32'h30;
      @(negedge clk);
      chk("abort_cpu_gnt", cpu_gnt, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      sb_q.delete();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h54; dma_req = 1; dma_we = 0; dma_addr = 32'h50;
      @(negedge clk);
      chk("abort_gnts", {cpu_gnt, dma_gnt}, 2'b00);
      chk("abort_enables", {mem_wr_en, mem_rd_en}, 2'b00);
      chk("abort_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
      chk("abort_cpu_rdata", cpu_rdata, 32'h0);
      chk("abort_dma_rdata", dma_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
      chk("post_rst_contention", {cpu_gnt, dma_gnt}, 2'b10);
      @(posedge clk); #1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
